branch_predictor_bht: RTL

//  Gshare branch-direction predictor paired with the branch comparator. Predicts br_en at fetch.
//  At resolve, the comparator's actual br_en trains the table. Sits beside fetch (predict port)
//  and execute (resolve port) in the pipelined rv32i core. It also keeps mispredict statistics.

---
 rtl/rv32i_types.sv | 25 ++
 rtl/bht_array.sv | 33 +++
 rtl/branch_predictor_bht.sv | 107 ++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared rv32i core types; holds the 2-bit branch history counter state and its update rule.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_t;

  // Saturating 2-bit counter step toward the observed outcome.
  function automatic bht_state_t bht_next(bht_state_t s, logic taken);
    bht_state_t n;
    case (s)
      SNT:     n = taken ? WNT : SNT;
      WNT:     n = taken ? WT  : SNT;
      WT:      n = taken ? ST  : WNT;
      default: n = taken ? ST  : WT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/bht_array.sv
// Table of 2-bit direction counters: one combinational read port and one
// read-modify-write training port; reads see the value before the same-edge update.
module bht_array
  import rv32i_types::*;
#(
  parameter int unsigned IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx_i,
  output bht_state_t       rd_state_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_taken_i
);

  localparam int unsigned Entries = 2 ** IDX_W;

  bht_state_t mem_q [Entries];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Entries; i++) begin
        mem_q[i] <= WNT;
      end
    end else if (wr_en_i) begin
      mem_q[wr_idx_i] <= bht_next(mem_q[wr_idx_i], wr_taken_i);
    end
  end

  assign rd_state_o = mem_q[rd_idx_i];

endmodule

// File: rtl/branch_predictor_bht.sv
// Gshare direction predictor: PC/history hash, registered prediction, non-speculative
// global history trained at resolve, and branch / mispredict statistics.
module branch_predictor_bht
  import rv32i_types::*;
#(
  parameter int unsigned IDX_W = 6,
  parameter int unsigned GHR_W = 6,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_req,
  input  rv32i_word        pred_pc,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             res_valid,
  input  logic [IDX_W-1:0] res_idx,
  input  logic             res_br_en,
  input  logic             res_pred,
  output logic             mispredict,
  output logic [GHR_W-1:0] ghr,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] miss_count
);

  logic             pred_valid_q, pred_valid_d;
  logic             pred_taken_q, pred_taken_d;
  logic [IDX_W-1:0] pred_idx_q, pred_idx_d;
  logic             mispredict_q, mispredict_d;
  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic [CNT_W-1:0] br_count_q, br_count_d;
  logic [CNT_W-1:0] miss_count_q, miss_count_d;

  logic [IDX_W-1:0] hash_idx;
  bht_state_t       rd_state;
  logic             unused_pc_bits;

  // History is zero-extended into the upper index bits when shorter than the index.
  assign hash_idx       = pred_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
  assign unused_pc_bits = ^{pred_pc[31:IDX_W+2], pred_pc[1:0]};

  bht_array #(
    .IDX_W (IDX_W)
  ) u_bht_array (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (hash_idx),
    .rd_state_o (rd_state),
    .wr_en_i    (res_valid),
    .wr_idx_i   (res_idx),
    .wr_taken_i (res_br_en)
  );

  always_comb begin
    pred_valid_d = pred_req;
    pred_taken_d = pred_taken_q;
    pred_idx_d   = pred_idx_q;
    mispredict_d = 1'b0;
    ghr_d        = ghr_q;
    br_count_d   = br_count_q;
    miss_count_d = miss_count_q;

    if (pred_req) begin
      pred_taken_d = rd_state[1];
      pred_idx_d   = hash_idx;
    end

    if (res_valid) begin
      ghr_d      = {ghr_q[GHR_W-2:0], res_br_en};
      br_count_d = br_count_q + CNT_W'(1);
      if (res_br_en != res_pred) begin
        mispredict_d = 1'b1;
        miss_count_d = miss_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_idx_q   <= '0;
      mispredict_q <= 1'b0;
      ghr_q        <= '0;
      br_count_q   <= '0;
      miss_count_q <= '0;
    end else begin
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      pred_idx_q   <= pred_idx_d;
      mispredict_q <= mispredict_d;
      ghr_q        <= ghr_d;
      br_count_q   <= br_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign pred_valid = pred_valid_q;
  assign pred_taken = pred_taken_q;
  assign pred_idx   = pred_idx_q;
  assign mispredict = mispredict_q;
  assign ghr        = ghr_q;
  assign br_count   = br_count_q;
  assign miss_count = miss_count_q;

endmodule
